bcd_code_conv: RTL and testbench

Sequential, parametrised multi-digit BCD code converter. It accepts a packed word of `DIGITS` 8421-BCD digits through a valid/ready handshake. It converts one digit per clock into one of four selectable target codes (excess-3, 2421 Aiken, nine's complement, Gray) and flags invalid digits individually. It returns the result through a second valid/ready handshake and sits between BCD arithmetic/counter blocks and display or transmit logic.

---
 rtl/bcd_code_conv.sv | 116 +++++++++++
 tb/tb_bcd_code_conv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_code_conv.sv
`timescale 1ns/1ps
// Purpose : multi-digit 8421-BCD word converter to excess-3, 2421, nine's complement or Gray,
//           one digit per clock, with per-digit invalid (>9) flags.
// Latency : out_valid rises after edge T0+DIGITS for an accept at edge T0; one word per DIGITS+2 cycles.
// Backpr. : in_ready is high only in IDLE; out_valid/out_data/err_digit hold steady until out_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data (4*DIGITS) and mode (2) sampled at accept
//   out_valid/out_ready output handshake; out_data (4*DIGITS) and err_digit (DIGITS)
module bcd_code_conv #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err_digit
);

  // Digit counter is at least one bit wide so DIGITS=1 still elaborates cleanly.
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  data_q;
  logic [1:0]           mode_q;

  logic [3:0]           cur_digit;
  logic [4:0]           cur_res;   // {invalid, code}

  // Single-digit map. Invalid digits produce 0000 regardless of mode.
  function automatic logic [4:0] conv_digit(input logic [1:0] m, input logic [3:0] d);
    logic [3:0] code;
    code = 4'd0;
    if (d > 4'd9) begin
      return {1'b1, 4'd0};
    end
    case (m)
      2'd0:    code = d + 4'd3;
      2'd1:    code = (d <= 4'd4) ? d : d + 4'd6;
      2'd2:    code = 4'd9 - d;
      default: code = d ^ (d >> 1);
    endcase
    return {1'b0, code};
  endfunction

  always_comb begin
    cur_digit = data_q[4*idx +: 4];
    cur_res   = conv_digit(mode_q, cur_digit);
  end

  // Handshake outputs are registered alongside the state so nothing on the
  // output side depends combinationally on in_* signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      data_q    <= '0;
      mode_q    <= 2'd0;
      out_data  <= '0;
      err_digit <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            mode_q    <= mode;
            out_data  <= '0;
            err_digit <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          out_data[4*idx +: 4] <= cur_res[3:0];
          err_digit[idx]       <= cur_res[4];
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_code_conv.sv
`timescale 1ns/1ps
// Purpose : randomized and directed check of bcd_code_conv against an arithmetic reference.
// Latency : drives one word at a time and measures accept-to-out_valid cycles.
// Backpr. : holds out_ready low for chosen cycles in DONE while pulsing in_valid.
module tb_bcd_code_conv;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [DIGITS-1:0] err_digit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_code_conv #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_digit (err_digit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain per-digit arithmetic, result packed as {err, data}.
  function automatic logic [W+DIGITS-1:0] ref_conv(input logic [1:0] m, input logic [W-1:0] data);
    logic [W-1:0]      o = '0;
    logic [DIGITS-1:0] e = '0;
    int d;
    int c;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'((data >> (4*k)) & W'(15));
      if (d > 9) begin
        e[k] = 1'b1;
        c = 0;
      end else begin
        case (m)
          2'd0:    c = d + 3;
          2'd1:    c = (d <= 4) ? d : d + 6;
          2'd2:    c = 9 - d;
          default: c = d ^ (d >> 1);
        endcase
      end
      o = o | (W'(c) << (4*k));
    end
    return {e, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [W-1:0] data, input logic [1:0] m,
                          input logic [W-1:0] exp_d, input logic [DIGITS-1:0] exp_e,
                          input int hold, input bit scramble, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check({tag, ":idle"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = data;
    mode      = m;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    check({tag, ":accept"}, {31'd0, in_ready}, 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      if (scramble) begin
        mode     = 2'($urandom);
        in_data  = W'($urandom);
        in_valid = 1'($urandom);
      end
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    check({tag, ":latency"}, cnt, DIGITS);
    check({tag, ":data"}, 32'(out_data), 32'(exp_d));
    check({tag, ":err"}, 32'(err_digit), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      check({tag, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ":hold_data"}, 32'(out_data), 32'(exp_d));
      check({tag, ":hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, ":release_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ":release_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W+DIGITS-1:0] r;
    logic [W-1:0]        rd;
    logic [1:0]          rm;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset:out_valid", {31'd0, out_valid}, 32'd0);
    check("reset:in_ready", {31'd0, in_ready}, 32'd1);
    check("reset:out_data", 32'(out_data), 32'd0);
    check("reset:err", 32'(err_digit), 32'd0);
    rst = 1'b0;
    tick();

    run_word(16'h1234, 2'd0, 16'h4567, 4'b0000, 0, 1'b0, "xs3");
    run_word(16'h5679, 2'd1, 16'hBCDF, 4'b0000, 0, 1'b0, "aiken");
    run_word(16'h0918, 2'd2, 16'h9081, 4'b0000, 0, 1'b0, "nines");
    run_word(16'h0789, 2'd3, 16'h04CD, 4'b0000, 0, 1'b1, "gray_toggle");
    run_word(16'h12A4, 2'd0, 16'h4507, 4'b0010, 0, 1'b0, "invalid");
    run_word(16'hFB90, 2'd1, 16'h00F0, 4'b1100, 1, 1'b0, "invalid_hi");
    run_word(16'h3210, 2'd3, 16'h2310, 4'b0000, 5, 1'b0, "backpressure");
    run_word(16'h8765, 2'd2, 16'h1234, 4'b0000, 0, 1'b0, "after_bp");

    // Abort a word two cycles into CONV, with both handshakes asserted in the reset cycle.
    in_valid = 1'b1;
    in_data  = 16'h5555;
    mode     = 2'd0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("midrst:out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst:out_data", 32'(out_data), 32'd0);
    check("midrst:err", 32'(err_digit), 32'd0);
    check("midrst:in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("midrst:still_idle", {31'd0, in_ready}, 32'd1);
    run_word(16'h9999, 2'd0, 16'hCCCC, 4'b0000, 0, 1'b0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      rd = W'($urandom);
      rm = 2'($urandom);
      r  = ref_conv(rm, rd);
      run_word(rd, rm, r[W-1:0], r[W+DIGITS-1:W], int'($urandom_range(0, 3)),
               1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
